// File: rtl/dti_burst_seq_if.sv
// Request, FIFO-read, downstream-beat and status signals of the burst sequencer.
// slave : the sequencer itself.
// master: whatever issues requests, feeds FIFO status and consumes beats.
interface dti_burst_seq_if #(
    parameter int WIDTH  = 32,
    parameter int BCNT_W = 16
);
    logic              req_valid;
    logic              req_ready;
    logic [WIDTH-1:0]  req_len;
    logic [1:0]        req_ratio;
    logic              abort;
    logic              fifo_empty;
    logic              fifo_rd_en;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic              busy;
    logic              done;
    logic              err;
    logic [WIDTH-1:0]  remaining;
    logic [BCNT_W-1:0] beat_cnt;

    modport slave (
        input  req_valid, req_len, req_ratio, abort, fifo_empty, out_ready,
        output req_ready, fifo_rd_en, out_valid, out_last, busy, done, err,
               remaining, beat_cnt
    );

    modport master (
        output req_valid, req_len, req_ratio, abort, fifo_empty, out_ready,
        input  req_ready, fifo_rd_en, out_valid, out_last, busy, done, err,
               remaining, beat_cnt
    );
endinterface

// File: rtl/dti_burst_seq.sv
// Read-side burst sequencer: takes a (length, units-per-beat) request, pops
// the FIFO once per downstream handshake, counts remaining units down with
// saturation, marks the final beat and pulses done one cycle after it.
module dti_burst_seq #(
    parameter int WIDTH  = 32,
    parameter int BCNT_W = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    dti_burst_seq_if.slave     bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic [WIDTH-1:0]  r_remaining;
    logic [BCNT_W-1:0] r_beat_cnt;
    logic [1:0]        r_ratio;
    logic              r_done;
    logic              r_err;

    logic [WIDTH-1:0]  w_step;
    logic              w_req_ready;
    logic              w_busy;
    logic              w_out_valid;
    logic              w_beat;
    logic              w_last;
    logic              w_accept;
    logic              w_req_illegal;
    logic              w_req_zero;
    logic              w_req_start;

    // Units consumed per beat, decoded from the ratio latched at request time.
    always_comb begin
        case (r_ratio)
            2'b01:   w_step = WIDTH'(2);
            2'b10:   w_step = WIDTH'(4);
            default: w_step = WIDTH'(1);
        endcase
    end

    // Request classification: illegal ratio wins over zero length.
    assign w_accept      = bus.req_valid & w_req_ready;
    assign w_req_illegal = w_accept & (bus.req_ratio == 2'b11);
    assign w_req_zero    = w_accept & ~w_req_illegal & (bus.req_len == '0);
    assign w_req_start   = w_accept & ~w_req_illegal & (bus.req_len != '0);

    // A beat is a handshake on the downstream port; the FIFO pops on it.
    // The final beat may carry fewer units than the step (partial beat).
    assign w_beat = w_out_valid & bus.out_ready;
    assign w_last = w_out_valid & (r_remaining <= w_step);

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and per-state handshake outputs.
    always_comb begin
        w_state_next = r_state;
        w_req_ready  = 1'b0;
        w_busy       = 1'b0;
        w_out_valid  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_req_ready = 1'b1;
                if (w_req_start) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                w_busy      = 1'b1;
                w_out_valid = ~bus.fifo_empty;
                if (bus.abort) begin
                    w_state_next = S_IDLE;
                end else if (w_beat && w_last) begin
                    w_state_next = S_FIN;
                end
            end
            S_FIN: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Remaining/beat counters, latched ratio and the done/err pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_remaining <= '0;
            r_beat_cnt  <= '0;
            r_ratio     <= 2'b00;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_req_illegal) begin
                        r_err <= 1'b1;
                    end else if (w_req_zero) begin
                        r_done     <= 1'b1;
                        r_beat_cnt <= '0;
                    end else if (w_req_start) begin
                        r_remaining <= bus.req_len;
                        r_ratio     <= bus.req_ratio;
                        r_beat_cnt  <= '0;
                    end
                end
                S_RUN: begin
                    // A handshake in the abort cycle still counts as a beat.
                    if (w_beat) begin
                        r_remaining <= (r_remaining > w_step) ? (r_remaining - w_step) : '0;
                        if (r_beat_cnt != '1) begin
                            r_beat_cnt <= r_beat_cnt + BCNT_W'(1);
                        end
                    end
                    if (bus.abort) begin
                        r_remaining <= '0;
                    end else if (w_beat && w_last) begin
                        r_done <= 1'b1;
                    end
                end
                S_FIN: begin
                    r_remaining <= '0;
                end
                default: begin
                    r_remaining <= '0;
                end
            endcase
        end
    end

    assign bus.req_ready  = w_req_ready;
    assign bus.busy       = w_busy;
    assign bus.out_valid  = w_out_valid;
    assign bus.fifo_rd_en = w_beat;
    assign bus.out_last   = w_last;
    assign bus.done       = r_done;
    assign bus.err        = r_err;
    assign bus.remaining  = r_remaining;
    assign bus.beat_cnt   = r_beat_cnt;

endmodule

// File: tb/tb_dti_burst_seq.sv
// Directed bench for dti_burst_seq: per-cycle expectations during transfers
// plus hand-computed totals for each scenario.
module tb_dti_burst_seq;

    localparam int WIDTH  = 32;
    localparam int BCNT_W = 16;

    logic clk;
    logic reset_n;

    int checks = 0;
    int errors = 0;
    int pops;
    int unsigned rem_hist[$];

    dti_burst_seq_if #(.WIDTH(WIDTH), .BCNT_W(BCNT_W)) bus ();

    dti_burst_seq #(.WIDTH(WIDTH), .BCNT_W(BCNT_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the run always ends.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one cycle; returns one cycle after the accept edge.
    task automatic req(input int unsigned len, input logic [1:0] ratio);
        bus.req_valid = 1'b1;
        bus.req_len   = len;
        bus.req_ratio = ratio;
        #1;
        check("req_ready_at_accept", bus.req_ready, 1);
        tick();
        bus.req_valid = 1'b0;
        bus.req_len   = '0;
        bus.req_ratio = 2'b00;
    endtask

    // Drive a transfer already in RUN to completion, checking each cycle,
    // then check the FIN cycle and the return to IDLE.
    task automatic run_xfer(input int unsigned len, input int unsigned st, input bit rnd);
        int unsigned rem = len;
        int unsigned cnt = 0;
        bit fin = 1'b0;
        bit ev, eb, el;
        pops = 0;
        rem_hist.delete();
        for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
            if (rnd) begin
                bus.fifo_empty = 1'($urandom_range(0, 1));
                bus.out_ready  = 1'($urandom_range(0, 1));
            end else begin
                bus.fifo_empty = 1'b0;
                bus.out_ready  = 1'b1;
            end
            #1;
            ev = !bus.fifo_empty;
            eb = ev && bus.out_ready;
            el = ev && (rem <= st);
            check("run_busy", bus.busy, 1);
            check("run_req_ready", bus.req_ready, 0);
            check("run_out_valid", bus.out_valid, ev);
            check("run_fifo_rd_en", bus.fifo_rd_en, eb);
            check("run_out_last", bus.out_last, el);
            check("run_remaining", bus.remaining, rem);
            check("run_done", bus.done, 0);
            if (eb) begin
                pops++;
                rem_hist.push_back(rem);
                rem = (rem > st) ? rem - st : 0;
                cnt++;
                if (el) fin = 1'b1;
            end
            tick();
        end
        check("fin_reached", fin, 1);
        bus.fifo_empty = 1'b0;
        bus.out_ready  = 1'b1;
        #1;
        check("fin_done", bus.done, 1);
        check("fin_busy", bus.busy, 0);
        check("fin_req_ready", bus.req_ready, 0);
        check("fin_out_valid", bus.out_valid, 0);
        check("fin_fifo_rd_en", bus.fifo_rd_en, 0);
        check("fin_remaining", bus.remaining, 0);
        check("fin_beat_cnt", bus.beat_cnt, cnt);
        tick();
        check("idle_done_low", bus.done, 0);
        check("idle_req_ready", bus.req_ready, 1);
        check("idle_busy", bus.busy, 0);
    endtask

    initial begin
        reset_n        = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_len    = '0;
        bus.req_ratio  = 2'b00;
        bus.abort      = 1'b0;
        bus.fifo_empty = 1'b0;
        bus.out_ready  = 1'b1;
        tick();
        tick();

        // Reset state
        check("rst_req_ready", bus.req_ready, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_fifo_rd_en", bus.fifo_rd_en, 0);
        check("rst_out_last", bus.out_last, 0);
        check("rst_done", bus.done, 0);
        check("rst_err", bus.err, 0);
        check("rst_remaining", bus.remaining, 0);
        check("rst_beat_cnt", bus.beat_cnt, 0);
        reset_n = 1'b1;
        tick();

        // 7 units, 1 unit per beat, no stalls
        req(7, 2'b00);
        run_xfer(7, 1, 1'b0);
        check("t1_pops", pops, 7);
        check("t1_beat_cnt_held", bus.beat_cnt, 7);
        check("t1_first_rem", rem_hist[0], 7);
        check("t1_last_rem", rem_hist[6], 1);

        // 10 units, 4 units per beat: 10 -> 6 -> 2 -> 0
        req(10, 2'b10);
        run_xfer(10, 4, 1'b0);
        check("t2_pops", pops, 3);
        check("t2_rem0", rem_hist[0], 10);
        check("t2_rem1", rem_hist[1], 6);
        check("t2_rem2", rem_hist[2], 2);
        check("t2_beat_cnt_held", bus.beat_cnt, 3);

        // 5 units, 2 per beat, random FIFO empty / downstream stalls
        req(5, 2'b01);
        run_xfer(5, 2, 1'b1);
        check("t3_pops", pops, 3);
        check("t3_beat_cnt_held", bus.beat_cnt, 3);

        // Zero length: done pulse, no pop, stays ready
        req(0, 2'b00);
        #1;
        check("t4_done", bus.done, 1);
        check("t4_err", bus.err, 0);
        check("t4_req_ready", bus.req_ready, 1);
        check("t4_fifo_rd_en", bus.fifo_rd_en, 0);
        check("t4_beat_cnt_clr", bus.beat_cnt, 0);
        tick();
        check("t4_done_pulse", bus.done, 0);

        // Illegal ratio: err pulse, stays idle
        req(5, 2'b11);
        #1;
        check("t4_err_pulse", bus.err, 1);
        check("t4_err_no_done", bus.done, 0);
        check("t4_err_idle", bus.busy, 0);
        check("t4_err_rem", bus.remaining, 0);
        tick();
        check("t4_err_low", bus.err, 0);

        // Abort after 4 beats, no beat in the abort cycle
        req(100, 2'b00);
        repeat (4) tick();
        check("t5_rem_pre", bus.remaining, 96);
        check("t5_cnt_pre", bus.beat_cnt, 4);
        bus.abort      = 1'b1;
        bus.fifo_empty = 1'b1;
        #1;
        check("t5_no_pop", bus.fifo_rd_en, 0);
        tick();
        bus.abort      = 1'b0;
        bus.fifo_empty = 1'b0;
        #1;
        check("t5_idle", bus.busy, 0);
        check("t5_req_ready", bus.req_ready, 1);
        check("t5_rem", bus.remaining, 0);
        check("t5_cnt", bus.beat_cnt, 4);
        check("t5_no_done", bus.done, 0);
        req(3, 2'b00);
        run_xfer(3, 1, 1'b0);
        check("t5_next_pops", pops, 3);

        // Abort with a beat in the abort cycle
        req(100, 2'b00);
        tick();
        bus.abort = 1'b1;
        #1;
        check("t5b_pop", bus.fifo_rd_en, 1);
        tick();
        bus.abort = 1'b0;
        #1;
        check("t5b_cnt", bus.beat_cnt, 2);
        check("t5b_rem", bus.remaining, 0);
        check("t5b_idle", bus.busy, 0);
        check("t5b_no_done", bus.done, 0);
        tick();

        // Asynchronous reset mid-transfer
        req(20, 2'b00);
        repeat (2) tick();
        check("t6_rem_pre", bus.remaining, 18);
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_busy", bus.busy, 0);
        check("t6_req_ready", bus.req_ready, 1);
        check("t6_out_valid", bus.out_valid, 0);
        check("t6_fifo_rd_en", bus.fifo_rd_en, 0);
        check("t6_out_last", bus.out_last, 0);
        check("t6_rem", bus.remaining, 0);
        check("t6_cnt", bus.beat_cnt, 0);
        check("t6_done", bus.done, 0);
        tick();
        reset_n = 1'b1;
        tick();
        req(3, 2'b00);
        run_xfer(3, 1, 1'b0);
        check("t6_next_pops", pops, 3);
        check("t6_next_cnt", bus.beat_cnt, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
